bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//  Multi-digit decimal counter with a built-in prescaler and run/pause control.
//  Advances once every TICK_DIV clocks while running. Sits directly upstream of
//  the per-digit hexDisplay decoders: each 4-bit slice of digits drives one HEX.
// PARAMETERS
//  TICK_DIV    50000000  clocks per count increment; must be >= 2
//  NUM_DIGITS  4         number of cascaded BCD digits; must be >= 1
// PORTS
//  CLOCK_50    in   1             sole clock; all logic on its rising edge
//  RESET_N     in   1             reset, synchronous, active-low
//  run_toggle  in   1             rising edge toggles run/pause; already synchronous and debounced
//  clear       in   1             synchronous clear of count and prescaler, level-sensitive
//  digits      out  4*NUM_DIGITS  BCD count; [3:0] = least significant digit
//  tick        out  1             one-cycle pulse on the edge the count advances
//  wrap        out  1             one-cycle pulse when the count rolls from all-9s to all-0s
//  running     out  1             1 = counting, 0 = paused
// BEHAVIOUR
//  Reset (RESET_N=0 at an edge; overrides everything, including mid-count):
//   - digits=0, prescaler=0, running=0, tick=0, wrap=0, run_toggle history reg=0.
//  Run control:
//   - run_prev is registered from run_toggle.
//   - rise = run_toggle & ~run_prev; a rise flips running at that edge.
//   - Increment logic uses the pre-edge running value, so a toggle takes effect from the next cycle.
//   - Holding run_toggle high gives exactly one toggle.
//  Prescaler (width $clog2(TICK_DIV)):
//   - While running: counts 0..TICK_DIV-1.
//   - At an edge with prescaler==TICK_DIV-1: prescaler<=0, tick<=1, count increments.
//   - Increment period is exactly TICK_DIV clocks.
//   - While paused: prescaler and digits hold; resume keeps the remaining phase.
//   - tick, wrap are 0 on every edge with no increment.
//  Count arithmetic (decimal ripple, all digits update on the same edge):
//   - digit0 increments on every increment.
//   - digit i increments only when digits 0..i-1 are all 9.
//   - A digit at 9 that increments goes to 0.
//   - No digit ever holds a value > 9.
//   - All digits 9 plus an increment: all digits 0 and wrap<=1, coincident with tick.
//  clear (when RESET_N=1):
//   - digits=0, prescaler=0, tick=0, wrap=0; running unchanged.
//   - Wins over a same-cycle increment; no tick is produced.
//   - A same-cycle run_toggle rise is still honoured.
//  Latency: outputs are registered; digits/tick/wrap change on the same edge.
// STRUCTURE
//  - Shared include bcd_defs.vh: localparams BCD_MAX=4'd9, BCD_ZERO=4'd0, BCD_W=4.
//  - Sub-module bcd_digit: one BCD digit register.
//     - Inputs: clk, rst_n, clr, inc.
//     - Outputs: q[3:0], at_max (q==9).
//     - Instantiated NUM_DIGITS times in a generate loop.
//     - inc(i) = inc(i-1) & at_max(i-1).
//  - Top level holds the prescaler, toggle edge detect, running flag, tick/wrap regs.
// TESTING (TICK_DIV=4, NUM_DIGITS=2 unless stated)
//  1. Release reset, pulse run_toggle 1 cycle:
//     running=1 next edge; tick every 4 clocks; digits 8'h00,01,02...
//  2. Run from 8'h08, two ticks:
//     digits 8'h09 then 8'h10; wrap stays 0.
//  3. Run from 8'h98, two ticks:
//     8'h99 then 8'h00; wrap=1 for exactly the cycle tick=1.
//  4. Pause 1 clock after a tick (prescaler=1), idle 20 clocks, resume:
//     digits unchanged during the pause; next tick 3 clocks after resume;
//     run_toggle held high 10 clocks toggles only once.
//  5. clear asserted at 8'h47 on the prescaler==3 edge:
//     digits=8'h00, tick=0, running stays 1; next tick 4 clocks later.
//  6. RESET_N=0 for 1 edge mid-count at 8'h63:
//     all outputs 0, running=0; no count until a new toggle.
//     Also run TICK_DIV=2, NUM_DIGITS=1 wrap 9->0.

Source files
------------

// File: rtl/bcd_time_counter_pkg.sv
// Shared BCD digit constants for the decimal time counter and its digit cells.
package bcd_time_counter_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_time_counter_digit.sv
// One decimal digit register: counts 0..9 on inc, rolls 9 -> 0, flags when it sits at 9.
module bcd_digit
    import bcd_time_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             at_max
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_ZERO;
        end else if (inc) begin
            // >= keeps the digit inside 0..9 even if an illegal code ever appeared
            q_d = (q_q >= BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// Prescaled multi-digit BCD counter with run/pause toggle and level clear,
// feeding one 7-segment decoder per 4-bit digit slice.
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    run_toggle,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    tick,
    output logic                    wrap,
    output logic                    running
);

    localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          run_prev_q;
    logic          running_q, running_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          rise;
    logic          advance;

    logic [NUM_DIGITS-1:0] inc_chain;
    logic [NUM_DIGITS-1:0] at_max;

    assign rise    = run_toggle & ~run_prev_q;
    // Pre-edge running value gates the advance, so a toggle acts from the next cycle
    assign advance = running_q & (presc_q == PS_LAST) & ~clear;

    always_comb begin
        running_d = running_q ^ rise;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else if (running_q) begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                wrap_d  = &at_max;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            presc_q    <= '0;
            run_prev_q <= 1'b0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            run_prev_q <= run_toggle;
            running_q  <= running_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                assign inc_chain[gi] = advance;
            end else begin : g_rest
                assign inc_chain[gi] = inc_chain[gi-1] & at_max[gi-1];
            end

            bcd_digit u_digit (
                .clk    (CLOCK_50),
                .rst_n  (RESET_N),
                .clr    (clear),
                .inc    (inc_chain[gi]),
                .q      (digits[4*gi +: 4]),
                .at_max (at_max[gi])
            );
        end
    endgenerate

    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign running = running_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench: TICK_DIV=4/NUM_DIGITS=2 main instance plus TICK_DIV=2/NUM_DIGITS=1 wrap instance.
module tb_bcd_time_counter;

    logic       clk;
    logic       rst_n;
    logic       run_t, clr;
    logic [7:0] digits;
    logic       tick, wrap, running;
    logic       run_t2, clr2;
    logic [3:0] digits2;
    logic       tick2, wrap2, running2;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;

    bcd_time_counter #(.TICK_DIV(4), .NUM_DIGITS(2)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .run_toggle (run_t),
        .clear      (clr),
        .digits     (digits),
        .tick       (tick),
        .wrap       (wrap),
        .running    (running)
    );

    bcd_time_counter #(.TICK_DIV(2), .NUM_DIGITS(1)) dut2 (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .run_toggle (run_t2),
        .clear      (clr2),
        .digits     (digits2),
        .tick       (tick2),
        .wrap       (wrap2),
        .running    (running2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_ticks(input int n);
        step(4 * n);
        cnt = (cnt + n) % 100;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run_t = 1'b0; clr = 1'b0; run_t2 = 1'b0; clr2 = 1'b0;
        step(2);
        checks++;
        if ({digits, tick, wrap, running} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got digits=%h tick=%b wrap=%b running=%b want all 0", digits, tick, wrap, running);
        end
        rst_n = 1'b1;
        step(3);
        checks++;
        if (digits !== 8'h00 || running !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got digits=%h running=%b tick=%b want 00 0 0", digits, running, tick);
        end
        $display("test_reset done digits=%h running=%b", digits, running);
    endtask

    task automatic test_run_start;
        run_t = 1'b1;
        step(1);
        run_t = 1'b0;
        checks++;
        if (running !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL start_running: got running=%b tick=%b want 1 0", running, tick);
        end
        for (int t = 1; t <= 3; t++) begin
            for (int k = 1; k <= 4; k++) begin
                step(1);
                checks++;
                if (tick !== (k == 4) || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL tick_period: tick %0d clk %0d got tick=%b wrap=%b want %b 0", t, k, tick, wrap, (k == 4));
                end
            end
            cnt++;
            checks++;
            if (digits !== to_bcd(cnt)) begin
                errors++;
                $display("FAIL count_seq: got %h want %h", digits, to_bcd(cnt));
            end
            $display("run_start tick %0d digits=%h", t, digits);
        end
    endtask

    task automatic test_carry;
        run_ticks(5);
        checks++;
        if (digits !== 8'h08) begin
            errors++;
            $display("FAIL reach_08: got %h want 08", digits);
        end
        run_ticks(1);
        checks++;
        if (digits !== 8'h09 || tick !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL carry_09: got digits=%h tick=%b wrap=%b want 09 1 0", digits, tick, wrap);
        end
        run_ticks(1);
        checks++;
        if (digits !== 8'h10 || tick !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL carry_10: got digits=%h tick=%b wrap=%b want 10 1 0", digits, tick, wrap);
        end
        $display("test_carry digits=%h", digits);
    endtask

    task automatic test_wrap;
        run_ticks(88);
        checks++;
        if (digits !== 8'h98) begin
            errors++;
            $display("FAIL reach_98: got %h want 98", digits);
        end
        run_ticks(1);
        checks++;
        if (digits !== 8'h99 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL at_99: got digits=%h wrap=%b want 99 0", digits, wrap);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if (wrap !== 1'b0 || tick !== 1'b0 || digits !== 8'h99) begin
                errors++;
                $display("FAIL pre_wrap: clk %0d got digits=%h tick=%b wrap=%b want 99 0 0", k, digits, tick, wrap);
            end
        end
        step(1);
        cnt = 0;
        checks++;
        if (digits !== 8'h00 || tick !== 1'b1 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse: got digits=%h tick=%b wrap=%b want 00 1 1", digits, tick, wrap);
        end
        $display("test_wrap digits=%h wrap=%b", digits, wrap);
    endtask

    task automatic test_pause;
        run_t = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if (running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold_toggle: clk %0d got running=%b tick=%b wrap=%b want 0 0 0", k, running, tick, wrap);
            end
        end
        run_t = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++;
            if (digits !== 8'h00 || tick !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL paused_idle: clk %0d got digits=%h tick=%b running=%b want 00 0 0", k, digits, tick, running);
            end
        end
        run_t = 1'b1;
        step(1);
        run_t = 1'b0;
        checks++;
        if (running !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL resume: got running=%b tick=%b want 1 0", running, tick);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks++;
            if (tick !== (k == 3)) begin
                errors++;
                $display("FAIL resume_phase: clk %0d got tick=%b want %b", k, tick, (k == 3));
            end
        end
        cnt = 1;
        checks++;
        if (digits !== 8'h01) begin
            errors++;
            $display("FAIL resume_count: got %h want 01", digits);
        end
        $display("test_pause digits=%h running=%b", digits, running);
    endtask

    task automatic test_clear;
        run_ticks(46);
        checks++;
        if (digits !== 8'h47) begin
            errors++;
            $display("FAIL reach_47: got %h want 47", digits);
        end
        step(3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        cnt = 0;
        checks++;
        if (digits !== 8'h00 || tick !== 1'b0 || wrap !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins: got digits=%h tick=%b wrap=%b running=%b want 00 0 0 1", digits, tick, wrap, running);
        end
        for (int k = 1; k <= 4; k++) begin
            step(1);
            checks++;
            if (tick !== (k == 4)) begin
                errors++;
                $display("FAIL post_clear_phase: clk %0d got tick=%b want %b", k, tick, (k == 4));
            end
        end
        cnt = 1;
        checks++;
        if (digits !== 8'h01) begin
            errors++;
            $display("FAIL post_clear_count: got %h want 01", digits);
        end
        $display("test_clear digits=%h", digits);
    endtask

    task automatic test_reset_mid;
        run_ticks(62);
        checks++;
        if (digits !== 8'h63) begin
            errors++;
            $display("FAIL reach_63: got %h want 63", digits);
        end
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        cnt = 0;
        checks++;
        if ({digits, tick, wrap, running} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: got digits=%h tick=%b wrap=%b running=%b want all 0", digits, tick, wrap, running);
        end
        step(10);
        checks++;
        if (digits !== 8'h00 || running !== 1'b0) begin
            errors++;
            $display("FAIL no_count_after_reset: got digits=%h running=%b want 00 0", digits, running);
        end
        run_t = 1'b1;
        step(1);
        run_t = 1'b0;
        run_ticks(1);
        checks++;
        if (digits !== 8'h01 || tick !== 1'b1) begin
            errors++;
            $display("FAIL restart_after_reset: got digits=%h tick=%b want 01 1", digits, tick);
        end
        $display("test_reset_mid digits=%h running=%b", digits, running);
    endtask

    task automatic test_clear_toggle;
        clr = 1'b1; run_t = 1'b1;
        step(1);
        clr = 1'b0; run_t = 1'b0;
        checks++;
        if (digits !== 8'h00 || running !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_toggle: got digits=%h running=%b tick=%b want 00 0 0", digits, running, tick);
        end
        step(8);
        checks++;
        if (digits !== 8'h00 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_toggle_hold: got digits=%h running=%b want 00 0", digits, running);
        end
        $display("test_clear_toggle digits=%h running=%b", digits, running);
    endtask

    task automatic test_small_wrap;
        run_t2 = 1'b1;
        step(1);
        run_t2 = 1'b0;
        checks++;
        if (running2 !== 1'b1 || digits2 !== 4'h0) begin
            errors++;
            $display("FAIL small_start: got running=%b digits=%h want 1 0", running2, digits2);
        end
        step(18);
        checks++;
        if (digits2 !== 4'h9 || tick2 !== 1'b1 || wrap2 !== 1'b0) begin
            errors++;
            $display("FAIL small_at_9: got digits=%h tick=%b wrap=%b want 9 1 0", digits2, tick2, wrap2);
        end
        step(1);
        checks++;
        if (tick2 !== 1'b0 || wrap2 !== 1'b0 || digits2 !== 4'h9) begin
            errors++;
            $display("FAIL small_gap: got digits=%h tick=%b wrap=%b want 9 0 0", digits2, tick2, wrap2);
        end
        step(1);
        checks++;
        if (digits2 !== 4'h0 || tick2 !== 1'b1 || wrap2 !== 1'b1) begin
            errors++;
            $display("FAIL small_wrap: got digits=%h tick=%b wrap=%b want 0 1 1", digits2, tick2, wrap2);
        end
        step(1);
        checks++;
        if (tick2 !== 1'b0 || wrap2 !== 1'b0) begin
            errors++;
            $display("FAIL small_wrap_pulse_len: got tick=%b wrap=%b want 0 0", tick2, wrap2);
        end
        $display("test_small_wrap digits=%h", digits2);
    endtask

    initial begin
        test_reset();
        test_run_start();
        test_carry();
        test_wrap();
        test_pause();
        test_clear();
        test_reset_mid();
        test_clear_toggle();
        test_small_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
